cpu_run_controller: RTL and testbench
=====================================

Name: cpu_run_controller

Overview:
- Synthesizable run controller for the multi-cycle CPU. It replaces the fixed-time reset and stop sequence with a parametrised one.
- Holds the CPU in reset for a programmable number of cycles, then releases it.
- Counts cycles and instruction fetches, and detects a halt: the same PC fetched repeatedly, as with a `j self` loop.
- Ends the run with done or timeout. Sits between the top-level clock/reset and the CPU's reset input, with status out to the bench, LEDs or a debug UART.

Parameters:
- PC_WIDTH, 32, width of the monitored PC.
- CNT_WIDTH, 32, width of the cycle and instruction counters.
- RESET_CYCLES, 1, cycles cpu_reset is held after a run starts; must be at least 1.
- MAX_CYCLES, 400, run-cycle budget before timeout; 0 disables timeout.
- HALT_REPEAT, 3, consecutive fetches of an identical PC that count as a halt; 0 disables halt detection.
- AUTO_START, 1, when 1 a run starts automatically on the first cycle after reset deasserts.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high controller reset.
- start  in  1  single-cycle pulse; starts a run from IDLE, DONE or TIMEOUT.
- abort  in  1  returns to IDLE from any state except IDLE; cpu_reset is reasserted.
- fetch_valid  in  1  high for the one cycle in which the CPU latches an instruction (IRWrite).
- pc  in  PC_WIDTH  CPU PC, sampled when fetch_valid is high.
- cpu_reset  out  1  reset to the CPU, active-high.
- running  out  1  high in state RUN.
- done  out  1  sticky; high in state DONE.
- timeout  out  1  sticky; high in state TIMEOUT.
- cycle_count  out  CNT_WIDTH  CPU-active cycles in the current or last run.
- instr_count  out  CNT_WIDTH  fetch_valid pulses in the current or last run.
- halt_pc  out  PC_WIDTH  PC that triggered the halt; 0 otherwise.

Behaviour:
- Clock and reset: one clock domain (clk). reset is synchronous and active-high.
- Reset values while reset is high:
  - state goes to IDLE.
  - cpu_reset = 1.
  - running, done and timeout = 0.
  - counters, halt_pc, last_pc and repeat count = 0.
- States and transitions:
  - IDLE: cpu_reset = 1. Moves to HOLD on start, or on the first post-reset cycle if AUTO_START = 1. AUTO_START fires only once per reset.
  - HOLD: cpu_reset = 1. A hold counter counts up to RESET_CYCLES, then the state moves to RUN. Entering HOLD clears cycle_count, instr_count, halt_pc and the repeat count.
  - RUN: cpu_reset = 0. cycle_count increments on every cycle spent in RUN.
    - On fetch_valid, instr_count increments.
    - If pc equals last_pc, the repeat count increments; otherwise it is set to 1 and last_pc = pc.
  - Halt: when a fetch makes the repeat count reach HALT_REPEAT, the state moves to DONE on the next edge and halt_pc = pc.
  - Timeout: when cycle_count reaches MAX_CYCLES in RUN, the state moves to TIMEOUT. cycle_count stops at MAX_CYCLES.
  - DONE and TIMEOUT: cpu_reset = 1 and counters are frozen. start goes to HOLD.
- Simultaneous events:
  - Halt and timeout on the same cycle: halt wins (DONE).
  - abort and start on the same cycle: abort wins.
  - abort in IDLE has no effect.
- Latency:
  - cpu_reset falls RESET_CYCLES+1 edges after start is sampled: 1 edge into HOLD, then RESET_CYCLES edges in HOLD.
  - done rises 1 cycle after the halting fetch.
- Counters saturate at all-ones and never wrap.
- reset mid-run: immediate return to IDLE on the next edge, all outputs at reset values, cpu_reset = 1.
- start in HOLD or RUN is ignored.
- fetch_valid outside RUN is ignored.

Decomposition:
- Shared package `cpu_run_pkg`:
  - state encoding localparams: IDLE = 0, HOLD = 1, RUN = 2, DONE = 3, TIMEOUT = 4 (3-bit).
  - default constants for RESET_CYCLES, MAX_CYCLES and HALT_REPEAT.
- One sub-module, `sat_counter`: parametrised width, clear, enable, saturating increment. Instantiated for cycle_count, instr_count, the hold counter and the repeat count.

Test Plan:
- AUTO_START = 1, RESET_CYCLES = 1, reset high for 1 cycle then low:
  - cpu_reset is low exactly 2 edges after reset falls.
  - running = 1.
- HALT_REPEAT = 3, fetches at PC 0x0, 0x4, 0x8, then 0x8 twice more (fetches 1-5):
  - done = 1 one cycle after fetch 5.
  - halt_pc = 0x8, instr_count = 5, cpu_reset = 1.
- MAX_CYCLES = 10, no repeating PC:
  - timeout = 1 after 10 RUN cycles.
  - cycle_count = 10, done = 0.
- Halt fetch on the same cycle that cycle_count reaches MAX_CYCLES:
  - done = 1, timeout = 0.
- reset asserted mid-RUN with cycle_count = 37:
  - next edge: IDLE, counters = 0, cpu_reset = 1.
  - with AUTO_START = 1, a new run follows.
- From DONE, start pulse:
  - counters clear on entry to HOLD.
  - cpu_reset is held RESET_CYCLES cycles, then RUN.
  - abort during that RUN returns to IDLE with done = 0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg
// Shared definitions for the CPU run controller: run-state encoding,
// default timing constants and a width helper for small counters.
package cpu_run_pkg;

  // Run-state encoding
  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_HOLD_ENC    = 3'd1;
  localparam logic [2:0] ST_RUN_ENC     = 3'd2;
  localparam logic [2:0] ST_DONE_ENC    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT_ENC = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE_ENC,
    S_HOLD    = ST_HOLD_ENC,
    S_RUN     = ST_RUN_ENC,
    S_DONE    = ST_DONE_ENC,
    S_TIMEOUT = ST_TIMEOUT_ENC
  } run_state_e;

  // Default run timing
  localparam int DEF_RESET_CYCLES = 1;
  localparam int DEF_MAX_CYCLES   = 400;
  localparam int DEF_HALT_REPEAT  = 3;

  // Bits needed to hold values 0..max_val (at least 1 bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_run_controller_sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk  in   clock
//   clr  in   clear; when en is also high the counter restarts at 1
//   en   in   count enable
//   q    out  current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // clr together with en counts the current event as the first one, which
  // lets the repeat counter "restart at 1" in a single cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = en ? W'(1) : '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Drives the CPU reset line through a run: holds the CPU in reset for
// RESET_CYCLES after a run starts, releases it, counts cycles and fetches,
// and ends the run on a halt (same PC fetched HALT_REPEAT times in a row)
// or when MAX_CYCLES run cycles have elapsed.
//   clk          in   system clock
//   reset        in   synchronous active-high controller reset
//   start        in   start pulse (accepted in IDLE, DONE, TIMEOUT)
//   abort        in   return to IDLE from any non-IDLE state
//   fetch_valid  in   CPU instruction-latch strobe
//   pc           in   CPU PC, sampled with fetch_valid
//   cpu_reset    out  reset to the CPU
//   running      out  high in RUN
//   done         out  high in DONE (halt detected)
//   timeout      out  high in TIMEOUT
//   cycle_count  out  RUN cycles of the current/last run
//   instr_count  out  fetches of the current/last run
//   halt_pc      out  PC that caused the halt, else 0
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int HALT_REPEAT  = DEF_HALT_REPEAT,
  parameter int AUTO_START   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 fetch_valid,
  input  logic [PC_WIDTH-1:0]  pc,
  output logic                 cpu_reset,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count,
  output logic [PC_WIDTH-1:0]  halt_pc
);

  localparam int HOLD_W = cnt_w(RESET_CYCLES);
  localparam int REP_W  = cnt_w(HALT_REPEAT);

  run_state_e          state_q, state_d;
  logic                cpu_reset_q, cpu_reset_d;
  logic                running_q, running_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic                auto_armed_q, auto_armed_d;
  logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
  logic [PC_WIDTH-1:0] halt_pc_q, halt_pc_d;

  logic [HOLD_W-1:0]    hold_cnt;
  logic [REP_W-1:0]     rep_cnt;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instr_cnt;

  logic in_run;
  logic fetch_run;
  logic same_pc;
  logic halt_hit;
  logic tmo_hit;
  logic hold_done;
  logic enter_hold;

  assign in_run    = (state_q == S_RUN);
  assign fetch_run = in_run && fetch_valid;
  assign same_pc   = (pc == last_pc_q);

  // The halting fetch is the one whose updated repeat count equals
  // HALT_REPEAT: either it extends a run of identical PCs to that length,
  // or HALT_REPEAT is 1 and any fetch qualifies.
  assign halt_hit  = (HALT_REPEAT != 0) && fetch_run &&
                     (same_pc ? (rep_cnt == REP_W'(HALT_REPEAT - 1))
                              : (HALT_REPEAT == 1));

  // Fires on the RUN cycle whose increment brings cycle_count to MAX_CYCLES.
  assign tmo_hit   = (MAX_CYCLES != 0) && in_run &&
                     (cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 1));

  assign hold_done = (hold_cnt == HOLD_W'(RESET_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // Auto start is a one-shot armed only by reset.
        if (auto_armed_q || (start && !abort)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (abort)          state_d = S_IDLE;
        else if (hold_done) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort)         state_d = S_IDLE;
        else if (halt_hit) state_d = S_DONE;
        else if (tmo_hit)  state_d = S_TIMEOUT;
      end
      S_DONE, S_TIMEOUT: begin
        if (abort)      state_d = S_IDLE;
        else if (start) state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) state_d = S_IDLE;

    auto_armed_d = reset && (AUTO_START != 0);

    last_pc_d = last_pc_q;
    if (reset)          last_pc_d = '0;
    else if (fetch_run) last_pc_d = pc;

    halt_pc_d = halt_pc_q;
    if (reset || enter_hold)                 halt_pc_d = '0;
    else if (halt_hit && (state_d == S_DONE)) halt_pc_d = pc;

    // Status outputs are registered copies of the next state.
    cpu_reset_d = (state_d != S_RUN);
    running_d   = (state_d == S_RUN);
    done_d      = (state_d == S_DONE);
    timeout_d   = (state_d == S_TIMEOUT);
  end

  assign enter_hold = (state_d == S_HOLD) && (state_q != S_HOLD);

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    auto_armed_q <= auto_armed_d;
    last_pc_q    <= last_pc_d;
    halt_pc_q    <= halt_pc_d;
    cpu_reset_q  <= cpu_reset_d;
    running_q    <= running_d;
    done_q       <= done_d;
    timeout_q    <= timeout_d;
  end

  // Hold counter restarts from 0 whenever the FSM is outside HOLD.
  sat_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk (clk),
    .clr (reset || (state_q != S_HOLD)),
    .en  (!reset && (state_q == S_HOLD)),
    .q   (hold_cnt)
  );

  // A fetch of a new PC clears and counts in the same cycle (count = 1).
  sat_counter #(.W(REP_W)) u_rep_cnt (
    .clk (clk),
    .clr (reset || enter_hold || (fetch_run && !same_pc)),
    .en  (!reset && fetch_run),
    .q   (rep_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
    .clk (clk),
    .clr (reset || enter_hold),
    .en  (!reset && in_run),
    .q   (cycle_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_instr_cnt (
    .clk (clk),
    .clr (reset || enter_hold),
    .en  (!reset && fetch_run),
    .q   (instr_cnt)
  );

  assign cpu_reset   = cpu_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_cnt;
  assign instr_count = instr_cnt;
  assign halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller.
//   dut_a: defaults with RESET_CYCLES=1, MAX_CYCLES=400 (auto start, halt, abort, mid-run reset)
//   dut_b: RESET_CYCLES=3, MAX_CYCLES=10, no auto start (timeout, halt vs timeout)
//   dut_c: 3-bit counters, timeout and halt detection disabled (saturation)
module tb_cpu_run_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a
  logic        a_reset, a_start, a_abort, a_fetch;
  logic [31:0] a_pc;
  logic        a_cpu_reset, a_running, a_done, a_timeout;
  logic [31:0] a_cyc, a_ins, a_hpc;
  // dut_b
  logic        b_reset, b_start, b_abort, b_fetch;
  logic [31:0] b_pc;
  logic        b_cpu_reset, b_running, b_done, b_timeout;
  logic [31:0] b_cyc, b_ins, b_hpc;
  // dut_c
  logic        c_cpu_reset, c_running, c_done, c_timeout;
  logic [2:0]  c_cyc, c_ins;
  logic [31:0] c_hpc;
  logic        c_fetch;
  logic [31:0] c_pc;
  logic        c_start, c_abort;

  assign c_fetch = 1'b1;
  assign c_pc    = 32'h0;
  assign c_start = 1'b0;
  assign c_abort = 1'b0;

  cpu_run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(1), .MAX_CYCLES(400),
    .HALT_REPEAT(3), .AUTO_START(1)
  ) dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .abort(a_abort),
    .fetch_valid(a_fetch), .pc(a_pc), .cpu_reset(a_cpu_reset),
    .running(a_running), .done(a_done), .timeout(a_timeout),
    .cycle_count(a_cyc), .instr_count(a_ins), .halt_pc(a_hpc)
  );

  cpu_run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(32), .RESET_CYCLES(3), .MAX_CYCLES(10),
    .HALT_REPEAT(3), .AUTO_START(0)
  ) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .abort(b_abort),
    .fetch_valid(b_fetch), .pc(b_pc), .cpu_reset(b_cpu_reset),
    .running(b_running), .done(b_done), .timeout(b_timeout),
    .cycle_count(b_cyc), .instr_count(b_ins), .halt_pc(b_hpc)
  );

  cpu_run_controller #(
    .PC_WIDTH(32), .CNT_WIDTH(3), .RESET_CYCLES(1), .MAX_CYCLES(0),
    .HALT_REPEAT(0), .AUTO_START(1)
  ) dut_c (
    .clk(clk), .reset(a_reset), .start(c_start), .abort(c_abort),
    .fetch_valid(c_fetch), .pc(c_pc), .cpu_reset(c_cpu_reset),
    .running(c_running), .done(c_done), .timeout(c_timeout),
    .cycle_count(c_cyc), .instr_count(c_ins), .halt_pc(c_hpc)
  );

  // Scoreboard: flags = {cpu_reset, running, done, timeout}
  typedef struct {
    int          which;
    string       tag;
    logic [3:0]  fl;
    logic [31:0] cy;
    logic [31:0] in_;
    logic [31:0] hp;
    bit          cc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] halt_pcs [5];

  task automatic push(input int which, input string tag, input logic [3:0] fl,
                      input logic [31:0] cy, input logic [31:0] in_,
                      input logic [31:0] hp, input bit cc);
    exp_t e;
    e.which = which; e.tag = tag; e.fl = fl; e.cy = cy; e.in_ = in_;
    e.hp = hp; e.cc = cc;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [3:0]  ofl;
    logic [31:0] ocy, oin, ohp;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.which)
        0: begin ofl = {a_cpu_reset, a_running, a_done, a_timeout}; ocy = a_cyc; oin = a_ins; ohp = a_hpc; end
        1: begin ofl = {b_cpu_reset, b_running, b_done, b_timeout}; ocy = b_cyc; oin = b_ins; ohp = b_hpc; end
        default: begin ofl = {c_cpu_reset, c_running, c_done, c_timeout}; ocy = {29'd0, c_cyc}; oin = {29'd0, c_ins}; ohp = c_hpc; end
      endcase
      checks++;
      assert (ofl === e.fl) else begin
        errors++;
        $error("FAIL %s flags(rst,run,done,tmo): got %b want %b", e.tag, ofl, e.fl);
      end
      if (e.cc) begin
        checks++;
        assert (ocy === e.cy) else begin
          errors++;
          $error("FAIL %s cycle_count: got %0d want %0d", e.tag, ocy, e.cy);
        end
        checks++;
        assert (oin === e.in_) else begin
          errors++;
          $error("FAIL %s instr_count: got %0d want %0d", e.tag, oin, e.in_);
        end
        checks++;
        assert (ohp === e.hp) else begin
          errors++;
          $error("FAIL %s halt_pc: got %h want %h", e.tag, ohp, e.hp);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_fetch = 1'b0; a_pc = '0;
    b_reset = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_fetch = 1'b0; b_pc = '0;
    halt_pcs[0] = 32'h0; halt_pcs[1] = 32'h4; halt_pcs[2] = 32'h8;
    halt_pcs[3] = 32'h8; halt_pcs[4] = 32'h8;

    // Reset state
    push(0, "a_reset", 4'b1000, 0, 0, 0, 1);
    push(1, "b_reset", 4'b1000, 0, 0, 0, 1);
    push(2, "c_reset", 4'b1000, 0, 0, 0, 1);
    tick();

    // Auto start: HOLD one edge after reset falls, RUN on the second
    a_reset = 1'b0; b_reset = 1'b0;
    push(0, "a_auto_hold", 4'b1000, 0, 0, 0, 1);
    push(1, "b_no_auto", 4'b1000, 0, 0, 0, 1);
    tick();
    push(0, "a_auto_run", 4'b0100, 0, 0, 0, 1);
    tick();

    // Halt on PC 0,4,8,8,8
    for (int i = 0; i < 5; i++) begin
      a_fetch = 1'b1; a_pc = halt_pcs[i];
      push(0, "a_halt_seq", (i == 4) ? 4'b1010 : 4'b0100, 32'(i + 1), 32'(i + 1),
           (i == 4) ? 32'h8 : 32'h0, 1);
      tick();
    end

    // Fetches in DONE are ignored, counters frozen
    a_fetch = 1'b1; a_pc = 32'h8;
    push(0, "a_done_frozen", 4'b1010, 5, 5, 32'h8, 1);
    tick();

    // Restart from DONE: counters clear on entry to HOLD
    a_fetch = 1'b0; a_start = 1'b1;
    push(0, "a_restart_hold", 4'b1000, 0, 0, 0, 1);
    push(2, "c_sat_reach", 4'b0100, 7, 7, 0, 1);
    tick();
    a_start = 1'b0;
    push(0, "a_restart_run", 4'b0100, 0, 0, 0, 1);
    tick();
    push(0, "a_run_cyc1", 4'b0100, 1, 0, 0, 1);
    tick();
    push(0, "a_run_cyc2", 4'b0100, 2, 0, 0, 1);
    push(2, "c_sat_hold", 4'b0100, 7, 7, 0, 1);
    tick();

    // Abort with simultaneous start during RUN: abort wins
    a_abort = 1'b1; a_start = 1'b1;
    push(0, "a_abort_run", 4'b1000, 0, 0, 0, 0);
    tick();
    // Abort in IDLE has no effect; auto start does not fire again
    a_start = 1'b0;
    push(0, "a_abort_idle", 4'b1000, 0, 0, 0, 0);
    tick();

    // Start from IDLE, run to cycle_count = 37, then reset mid-run
    a_abort = 1'b0; a_start = 1'b1;
    push(0, "a_idle_start", 4'b1000, 0, 0, 0, 1);
    tick();
    a_start = 1'b0;
    push(0, "a_run2", 4'b0100, 0, 0, 0, 1);
    tick();
    repeat (36) tick();
    push(0, "a_cyc37", 4'b0100, 37, 0, 0, 1);
    tick();
    a_reset = 1'b1;
    push(0, "a_midrun_reset", 4'b1000, 0, 0, 0, 1);
    tick();
    a_reset = 1'b0;
    push(0, "a_rerun_hold", 4'b1000, 0, 0, 0, 1);
    tick();
    push(0, "a_rerun_run", 4'b0100, 0, 0, 0, 1);
    tick();

    // dut_b: start with a 3-cycle hold
    b_start = 1'b1;
    push(1, "b_hold1", 4'b1000, 0, 0, 0, 1);
    tick();
    b_start = 1'b0;
    push(1, "b_hold2", 4'b1000, 0, 0, 0, 1);
    tick();
    push(1, "b_hold3", 4'b1000, 0, 0, 0, 1);
    tick();
    push(1, "b_run", 4'b0100, 0, 0, 0, 1);
    tick();

    // Timeout after 10 RUN cycles, distinct PCs; start mid-run is ignored
    for (int k = 1; k <= 10; k++) begin
      b_fetch = 1'b1; b_pc = 32'(k * 4); b_start = (k == 5);
      push(1, "b_tmo_seq", (k == 10) ? 4'b1001 : 4'b0100, 32'(k), 32'(k), 0, 1);
      tick();
    end
    b_start = 1'b0; b_fetch = 1'b1; b_pc = 32'h40;
    push(1, "b_tmo_frozen", 4'b1001, 10, 10, 0, 1);
    tick();

    // Restart from TIMEOUT; halt lands on the timeout cycle and wins
    b_fetch = 1'b0; b_start = 1'b1;
    push(1, "b_restart_hold", 4'b1000, 0, 0, 0, 1);
    tick();
    b_start = 1'b0;
    push(1, "b_restart_hold2", 4'b1000, 0, 0, 0, 1);
    tick();
    push(1, "b_restart_hold3", 4'b1000, 0, 0, 0, 1);
    tick();
    push(1, "b_restart_run", 4'b0100, 0, 0, 0, 1);
    tick();
    for (int k = 1; k <= 10; k++) begin
      b_fetch = (k >= 8); b_pc = 32'h100;
      push(1, "b_halt_vs_tmo", (k == 10) ? 4'b1010 : 4'b0100, 32'(k),
           (k >= 8) ? 32'(k - 7) : 32'd0, (k == 10) ? 32'h100 : 32'h0, 1);
      tick();
    end

    // Abort with start in DONE: back to IDLE
    b_fetch = 1'b0; b_abort = 1'b1; b_start = 1'b1;
    push(1, "b_abort_done", 4'b1000, 0, 0, 0, 0);
    tick();
    b_abort = 1'b0; b_start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
